// File: rtl/btn_event_fifo.sv
// Turns debounced button edges into a queue of {index, press} events behind a
// first-word-fall-through valid/ready FIFO. Define BTN_RELEASE_EVENTS_EN to also queue release events.
module btn_event_fifo #(
  parameter int BITS  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     CPU_RESET,
  input  logic [BITS-1:0]          BTN_IN,
  output logic                     EVT_VALID,
  input  logic                     EVT_READY,
  output logic [$clog2(BITS)-1:0]  EVT_CODE,
  output logic                     EVT_PRESS,
  output logic [$clog2(DEPTH):0]   EVT_COUNT,
  output logic                     OVERFLOW,
  input  logic                     OVERFLOW_CLR
);

  localparam int CW = $clog2(BITS);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = CW + 1;

  // Handshake: the head entry moves out on any rising edge where EVT_VALID and
  // EVT_READY are both high; EVT_CODE/EVT_PRESS hold steady while EVT_VALID && !EVT_READY.

  function automatic logic [CW-1:0] lowest_idx(input logic [BITS-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  logic [BITS-1:0] btn_q;
  logic [BITS-1:0] pend_p_q, pend_p_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic [BITS-1:0] rise;
  logic [BITS-1:0] svc_p;
  logic            pop, full, can_push, push, lost;
  logic [EW-1:0]   push_data;

`ifdef BTN_RELEASE_EVENTS_EN
  logic [BITS-1:0] pend_r_q, pend_r_d;
  logic [BITS-1:0] fall;
  logic [BITS-1:0] svc_r;
`endif

  always_comb begin
    rise      = BTN_IN & ~btn_q;
    pop       = EVT_VALID & EVT_READY;
    full      = (count_q == (PW+1)'(DEPTH));
    can_push  = ~full | pop;
    // Isolate the lowest set pending bit; presses always win over releases.
    svc_p     = (can_push && (|pend_p_q)) ? (pend_p_q & (~pend_p_q + BITS'(1))) : '0;
    push_data = {lowest_idx(pend_p_q), 1'b1};
    lost      = |(rise & pend_p_q & ~svc_p);
    pend_p_d  = (pend_p_q & ~svc_p) | rise;
`ifdef BTN_RELEASE_EVENTS_EN
    fall      = ~BTN_IN & btn_q;
    svc_r     = (can_push && !(|pend_p_q) && (|pend_r_q)) ?
                (pend_r_q & (~pend_r_q + BITS'(1))) : '0;
    if (!(|pend_p_q)) push_data = {lowest_idx(pend_r_q), 1'b0};
    lost      = lost | (|(fall & pend_r_q & ~svc_r));
    pend_r_d  = (pend_r_q & ~svc_r) | fall;
    push      = (|svc_p) | (|svc_r);
`else
    push      = |svc_p;
`endif

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);

    if (lost)              ovf_d = 1'b1;
    else if (OVERFLOW_CLR) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge CLOCK) begin
    if (CPU_RESET) begin
      btn_q    <= BTN_IN;
      pend_p_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      btn_q    <= BTN_IN;
      pend_p_q <= pend_p_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef BTN_RELEASE_EVENTS_EN
  always_ff @(posedge CLOCK) begin
    if (CPU_RESET) pend_r_q <= '0;
    else           pend_r_q <= pend_r_d;
  end
`endif

  // Storage needs no reset: the outputs are gated by EVT_VALID.
  always_ff @(posedge CLOCK) begin
    if (!CPU_RESET && push) mem_q[wr_ptr_q] <= push_data;
  end

  assign EVT_VALID = (count_q != '0);
  assign EVT_COUNT = count_q;
  assign EVT_CODE  = EVT_VALID ? mem_q[rd_ptr_q][EW-1:1] : '0;
  assign EVT_PRESS = EVT_VALID ? mem_q[rd_ptr_q][0] : 1'b0;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_btn_event_fifo.sv
// Bench for btn_event_fifo: directed scenarios then random button/ready traffic,
// every cycle compared against an event-queue reference model.
module tb_btn_event_fifo;

  logic        CLOCK = 1'b0;
  logic        CPU_RESET = 1'b0;
  logic [15:0] BTN_IN = '0;
  logic        EVT_VALID;
  logic        EVT_READY = 1'b0;
  logic [3:0]  EVT_CODE;
  logic        EVT_PRESS;
  logic [3:0]  EVT_COUNT;
  logic        OVERFLOW;
  logic        OVERFLOW_CLR = 1'b0;

  btn_event_fifo #(.BITS(16), .DEPTH(8)) dut (
    .CLOCK(CLOCK), .CPU_RESET(CPU_RESET), .BTN_IN(BTN_IN),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_PRESS(EVT_PRESS), .EVT_COUNT(EVT_COUNT), .OVERFLOW(OVERFLOW),
    .OVERFLOW_CLR(OVERFLOW_CLR)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: previous levels, pending sets, event queue {code, press}.
  logic [15:0] m_btn = '0;
  logic [15:0] m_pp  = '0;
  logic [15:0] m_pr  = '0;
  logic        m_ovf = 1'b0;
  logic [4:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [15:0] b, input logic rdy, input logic clr, input logic rst);
    logic [15:0] rise;
    int svc_p, svc_r;
    bit pop, can_push, lost;
    if (rst) begin
      m_btn = b; m_pp = '0; m_pr = '0; m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    pop      = (exp_q.size() != 0) && rdy;
    can_push = (exp_q.size() < 8) || pop;
    svc_p = -1;
    svc_r = -1;
    if (can_push) begin
      for (int i = 0; i < 16; i++) if (m_pp[i]) begin svc_p = i; break; end
      if (svc_p < 0)
        for (int i = 0; i < 16; i++) if (m_pr[i]) begin svc_r = i; break; end
    end
    rise = b & ~m_btn;
    lost = 1'b0;
    for (int i = 0; i < 16; i++)
      if (rise[i] && m_pp[i] && i != svc_p) lost = 1'b1;
`ifdef BTN_RELEASE_EVENTS_EN
    begin
      logic [15:0] fall;
      fall = ~b & m_btn;
      for (int i = 0; i < 16; i++)
        if (fall[i] && m_pr[i] && i != svc_r) lost = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (svc_p >= 0) begin exp_q.push_back({4'(svc_p), 1'b1}); m_pp[svc_p] = 1'b0; end
      if (svc_r >= 0) begin exp_q.push_back({4'(svc_r), 1'b0}); m_pr[svc_r] = 1'b0; end
      m_pr = m_pr | fall;
    end
`else
    if (pop) void'(exp_q.pop_front());
    if (svc_p >= 0) begin exp_q.push_back({4'(svc_p), 1'b1}); m_pp[svc_p] = 1'b0; end
`endif
    m_pp = m_pp | rise;
    if (lost)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_btn = b;
  endtask

  // One clock: drive at negedge, advance model, sample 1 ns after the edge.
  task automatic step(input logic [15:0] b, input logic rdy, input logic clr, input logic rst);
    logic [4:0] head;
    @(negedge CLOCK);
    BTN_IN = b; EVT_READY = rdy; OVERFLOW_CLR = clr; CPU_RESET = rst;
    model_step(b, rdy, clr, rst);
    @(posedge CLOCK);
    #1;
    head = (exp_q.size() != 0) ? exp_q[0] : 5'd0;
    chk("valid", EVT_VALID, (exp_q.size() != 0) ? 1 : 0);
    chk("count", EVT_COUNT, exp_q.size());
    chk("code", EVT_CODE, head[4:1]);
    chk("press", EVT_PRESS, head[0]);
    chk("overflow", OVERFLOW, m_ovf);
  endtask

  initial begin
    logic [15:0] b;
    int rdy_pct;

    // Button held through reset creates no event.
    step(16'h0001, 0, 0, 1);
    step(16'h0001, 0, 0, 1);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_code", EVT_CODE, 0);
    chk("rst_press", EVT_PRESS, 0);
    chk("rst_ovf", OVERFLOW, 0);
    repeat (10) step(16'h0001, 0, 0, 0);
    chk("held_valid", EVT_VALID, 0);
    chk("held_count", EVT_COUNT, 0);

    // Single press: visible two edges after the input changes.
    step(16'h0000, 0, 0, 1);
    step(16'h0020, 0, 0, 0);
    chk("single_lat1", EVT_VALID, 0);
    step(16'h0020, 0, 0, 0);
    chk("single_valid", EVT_VALID, 1);
    chk("single_code", EVT_CODE, 5);
    chk("single_press", EVT_PRESS, 1);
    chk("single_count", EVT_COUNT, 1);
    step(16'h0020, 1, 0, 0);
    chk("single_pop", EVT_COUNT, 0);

    // Simultaneous presses serialise lowest index first.
    step(16'h0000, 0, 0, 1);
    step(16'h8101, 1, 0, 0);
    chk("sim_lat", EVT_VALID, 0);
    step(16'h8101, 1, 0, 0);
    chk("sim_code0", EVT_CODE, 0);
    step(16'h8101, 1, 0, 0);
    chk("sim_code8", EVT_CODE, 8);
    step(16'h8101, 1, 0, 0);
    chk("sim_code15", EVT_CODE, 15);
    step(16'h8101, 1, 0, 0);
    chk("sim_empty", EVT_VALID, 0);

    // Fill the FIFO; bits 8 and 9 wait in the pending vector.
    step(16'h0000, 0, 0, 1);
    b = '0;
    for (int i = 0; i < 10; i++) begin
      b[i] = 1'b1;
      step(b, 0, 0, 0);
    end
    step(b, 0, 0, 0);
    step(b, 0, 0, 0);
    chk("full_count", EVT_COUNT, 8);
    chk("full_ovf", OVERFLOW, 0);

    // Re-press of a still-pending bit is merged and flagged.
    b[9] = 1'b0; step(b, 0, 0, 0);
    b[9] = 1'b1; step(b, 0, 0, 0);
    chk("ovf_set", OVERFLOW, 1);
    step(b, 0, 1, 0);
    chk("ovf_clr", OVERFLOW, 0);
    b[8] = 1'b0; step(b, 0, 0, 0);
    b[8] = 1'b1; step(b, 0, 1, 0);
    chk("ovf_set_wins", OVERFLOW, 1);
    step(b, 1, 0, 0);
    chk("drain_code1", EVT_CODE, 1);
    repeat (20) step(b, 1, 0, 0);
    chk("drain_empty", EVT_VALID, 0);

    // Press then release of bit 3.
    step(16'h0000, 0, 0, 1);
    step(16'h0008, 0, 0, 0);
    repeat (5) step(16'h0008, 0, 0, 0);
    step(16'h0000, 0, 0, 0);
    repeat (3) step(16'h0000, 0, 0, 0);
`ifdef BTN_RELEASE_EVENTS_EN
    chk("rel_count", EVT_COUNT, 2);
`else
    chk("rel_count", EVT_COUNT, 1);
`endif
    chk("rel_code", EVT_CODE, 3);
    chk("rel_press1", EVT_PRESS, 1);
    step(16'h0000, 1, 0, 0);
`ifdef BTN_RELEASE_EVENTS_EN
    chk("rel_code2", EVT_CODE, 3);
    chk("rel_press0", EVT_PRESS, 0);
`else
    chk("rel_none", EVT_VALID, 0);
`endif
    step(16'h0000, 1, 0, 0);

    // Random traffic with varying consumer speed.
    b = '0;
    for (int n = 0; n < 2000; n++) begin
      rdy_pct = (n < 700) ? 25 : (n < 1400 ? 90 : 60);
      if ($urandom_range(3, 0) == 0) b[$urandom_range(15, 0)] ^= 1'b1;
      if ($urandom_range(7, 0) == 0) b[$urandom_range(15, 0)] ^= 1'b1;
      step(b, ($urandom_range(99, 0) < rdy_pct), ($urandom_range(15, 0) == 0),
           ($urandom_range(399, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
